// File: rtl/reg_wb_queue.sv
// In-order register writeback queue with late load-data fill and optional forwarding lookups.
// Forwarding is built only when REG_WB_QUEUE_FWD_EN is defined; otherwise fwd_* outputs are tied to 0.
module reg_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_wdata,
    input  logic        in_wait,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic [4:0]  fwd_raddr1,
    input  logic [4:0]  fwd_raddr2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2,
    output logic        fwd_stall1,
    output logic        fwd_stall2,
    output logic        rsp_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] ok_reg;
    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic             rsp_err_reg;

    // slot_idx[k] is the physical slot of the k-th oldest entry.
    logic [PW-1:0]    slot_idx [DEPTH];
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_idx[gi] = head_reg + PW'(gi);
    end

    logic head_ok;
    logic push;
    logic pop;
    logic wait_hit;
    logic [PW-1:0] wait_idx;

    assign in_ready = (count_reg < CW'(DEPTH));
    assign head_ok  = valid_reg[head_reg] & ok_reg[head_reg];
    assign pop      = head_ok;
    assign push     = in_valid & in_ready & ~flush;

    assign we      = head_ok & (addr_mem[head_reg] != 5'd0);
    assign waddr   = head_ok ? addr_mem[head_reg] : 5'd0;
    assign wdata   = head_ok ? data_mem[head_reg] : 32'd0;
    assign rsp_err = rsp_err_reg;

    // Scan youngest to oldest so the oldest waiting entry is the one kept.
    always_comb begin
        wait_hit = 1'b0;
        wait_idx = head_reg;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_reg[slot_idx[i]] && !ok_reg[slot_idx[i]]) begin
                wait_hit = 1'b1;
                wait_idx = slot_idx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg   <= '0;
            ok_reg      <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            rsp_err_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= '0;
            ok_reg    <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PW'(1);
            end
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                ok_reg[tail_reg]    <= ~in_wait;
                tail_reg            <= tail_reg + PW'(1);
            end
            if (mem_rvalid) begin
                if (wait_hit) begin
                    ok_reg[wait_idx] <= 1'b1;
                end else begin
                    rsp_err_reg <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by valid_reg/ok_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= in_waddr;
            data_mem[tail_reg] <= in_wdata;
        end
        if (mem_rvalid && wait_hit && !flush) begin
            data_mem[wait_idx] <= mem_rdata;
        end
    end

`ifdef REG_WB_QUEUE_FWD_EN
    for (gi = 0; gi < 2; gi++) begin : g_fwd
        logic [4:0]  ra;
        logic        hit;
        logic        stall;
        logic [31:0] data;

        assign ra = (gi == 0) ? fwd_raddr1 : fwd_raddr2;

        // Oldest to youngest: a later (younger) match overrides an earlier one.
        always_comb begin
            hit   = 1'b0;
            stall = 1'b0;
            data  = 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_reg[slot_idx[i]] && (ra != 5'd0) && (addr_mem[slot_idx[i]] == ra)) begin
                    hit   = 1'b1;
                    stall = ~ok_reg[slot_idx[i]];
                    data  = data_mem[slot_idx[i]];
                end
            end
        end
    end

    assign fwd_hit1   = g_fwd[0].hit;
    assign fwd_hit2   = g_fwd[1].hit;
    assign fwd_stall1 = g_fwd[0].stall;
    assign fwd_stall2 = g_fwd[1].stall;
    assign fwd_data1  = g_fwd[0].data;
    assign fwd_data2  = g_fwd[1].data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_raddr1, fwd_raddr2};

    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_stall1 = 1'b0;
    assign fwd_stall2 = 1'b0;
    assign fwd_data1  = 32'd0;
    assign fwd_data2  = 32'd0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: a queue-based reference model checked every negedge,
// plus literal expectations at the scenario milestones.
module tb_reg_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_waddr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_wait = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        flush = 1'b0;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  fwd_raddr1 = '0;
    logic [4:0]  fwd_raddr2 = '0;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic        fwd_stall1, fwd_stall2;
    logic        rsp_err;

    always #5 clk = ~clk;

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wait(in_wait),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .we(we), .waddr(waddr), .wdata(wdata),
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .fwd_stall1(fwd_stall1), .fwd_stall2(fwd_stall2),
        .rsp_err(rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: entries in arrival order, index 0 is the oldest.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        ok;
    } ent_t;
    ent_t mq[$];
    logic m_err = 1'b0;

    function automatic void lookup(input logic [4:0] ra, output logic hit,
                                   output logic st, output logic [31:0] d);
        hit = 1'b0;
        st  = 1'b0;
        d   = 32'd0;
        if (ra != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == ra) begin
                    hit = 1'b1;
                    st  = !mq[i].ok;
                    d   = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    task automatic model_step();
        int   n;
        int   w;
        logic can_push;
        logic do_pop;
        ent_t e;
        if (flush) begin
            mq.delete();
            return;
        end
        n        = mq.size();
        can_push = (n < DEPTH);
        do_pop   = (n > 0) && mq[0].ok;
        if (mem_rvalid) begin
            w = -1;
            for (int i = 0; i < n; i++) begin
                if (!mq[i].ok) begin
                    w = i;
                    break;
                end
            end
            if (w < 0) begin
                m_err = 1'b1;
            end else begin
                e    = mq[w];
                e.d  = mem_rdata;
                e.ok = 1'b1;
                mq[w] = e;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (in_valid && can_push) begin
            e.a  = in_waddr;
            e.d  = in_wdata;
            e.ok = !in_wait;
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        logic        p;
        logic [4:0]  ha;
        logic [31:0] hd;
        logic        h1, s1, h2, s2;
        logic [31:0] d1, d2;
        p = 1'b0; ha = '0; hd = '0;
        if (mq.size() > 0 && mq[0].ok) begin
            p  = 1'b1;
            ha = mq[0].a;
            hd = mq[0].d;
        end
        chk("in_ready", in_ready, 32'(mq.size() < DEPTH));
        chk("we", we, 32'(p && ha != 5'd0));
        chk("waddr", waddr, 32'(ha));
        chk("wdata", wdata, hd);
        chk("rsp_err", rsp_err, 32'(m_err));
`ifdef REG_WB_QUEUE_FWD_EN
        lookup(fwd_raddr1, h1, s1, d1);
        lookup(fwd_raddr2, h2, s2, d2);
`else
        h1 = 1'b0; s1 = 1'b0; d1 = '0;
        h2 = 1'b0; s2 = 1'b0; d2 = '0;
`endif
        chk("fwd_hit1", fwd_hit1, 32'(h1));
        chk("fwd_stall1", fwd_stall1, 32'(s1));
        chk("fwd_hit2", fwd_hit2, 32'(h2));
        chk("fwd_stall2", fwd_stall2, 32'(s2));
        if (!h1 || !s1) chk("fwd_data1", fwd_data1, d1);
        if (!h2 || !s2) chk("fwd_data2", fwd_data2, d2);
    endtask

    initial forever begin
        @(negedge clk);
        compare_all();
    end

    task automatic tick();
        @(posedge clk);
        if (resetn) model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic w,
                         input logic rv, input logic [31:0] rd, input logic fl);
        in_valid   = v;
        in_waddr   = a;
        in_wdata   = d;
        in_wait    = w;
        mem_rvalid = rv;
        mem_rdata  = rd;
        flush      = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_we", we, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_fwd_hit1", fwd_hit1, 0);
        tick(); tick();
        resetn = 1'b1;

        // Single immediate-data push.
        drive(1, 5'd5, 32'h1234, 0, 0, 0, 0); tick(); idle(); #1;
        chk("r5_we", we, 1);
        chk("r5_waddr", waddr, 5);
        chk("r5_wdata", wdata, 32'h1234);
        tick();
        chk("r5_drained_ready", in_ready, 1);
        chk("r5_drained_we", we, 0);

        // Load followed by ALU result: order preserved, load blocks the head.
        drive(1, 5'd7, 32'h5555, 1, 0, 0, 0); tick();
        drive(1, 5'd8, 32'hAA, 0, 0, 0, 0); tick();
        idle(); tick();
        chk("ld_wait_we", we, 0);
        drive(0, 0, 0, 0, 1, 32'hDEAD, 0); #1;
        chk("ld_ret_cycle_we", we, 0);
        tick(); idle(); #1;
        chk("ld_r7_we", we, 1);
        chk("ld_r7_waddr", waddr, 7);
        chk("ld_r7_wdata", wdata, 32'hDEAD);
        tick();
        chk("ld_r8_waddr", waddr, 8);
        chk("ld_r8_wdata", wdata, 32'hAA);
        tick();
        chk("ld_done_we", we, 0);

        // Forwarding: youngest of two r3 entries wins; r0 never hits.
        drive(1, 5'd9, 32'h7777, 1, 0, 0, 0); tick();
        drive(1, 5'd3, 32'h11, 0, 0, 0, 0); tick();
        drive(1, 5'd3, 32'h22, 0, 0, 0, 0); tick();
        idle(); fwd_raddr1 = 5'd3; fwd_raddr2 = 5'd0; #1;
`ifdef REG_WB_QUEUE_FWD_EN
        chk("fwd_r3_hit", fwd_hit1, 1);
        chk("fwd_r3_data", fwd_data1, 32'h22);
        chk("fwd_r3_stall", fwd_stall1, 0);
        chk("fwd_r0_hit", fwd_hit2, 0);
`else
        chk("fwd_off_hit", fwd_hit1, 0);
        chk("fwd_off_data", fwd_data1, 0);
`endif
        tick();
        fwd_raddr1 = 5'd9; fwd_raddr2 = 5'd3; #1;
`ifdef REG_WB_QUEUE_FWD_EN
        chk("fwd_r9_hit", fwd_hit1, 1);
        chk("fwd_r9_stall", fwd_stall1, 1);
        chk("fwd_r3b_data", fwd_data2, 32'h22);
`else
        chk("fwd_off_stall", fwd_stall1, 0);
`endif
        drive(0, 0, 0, 0, 1, 32'h99, 0); tick();
        idle(); repeat (4) tick();
        fwd_raddr1 = 5'd0; fwd_raddr2 = 5'd0;

        // Fill with loads; 5th request refused; one return frees a slot.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 32'hC0DE0000 + 32'(i), 1, 0, 0, 0); tick();
        end
        drive(1, 5'd6, 32'h66, 0, 0, 0, 0); #1;
        chk("full_ready", in_ready, 0);
        tick(); idle(); tick();
        chk("full_no_write", we, 0);
        drive(0, 0, 0, 0, 1, 32'h100, 0); tick(); idle(); #1;
        chk("full_pop_we", we, 1);
        chk("full_pop_wdata", wdata, 32'h100);
        chk("full_pop_ready_same", in_ready, 0);
        tick();
        chk("full_ready_after", in_ready, 1);
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 0, 0, 1, 32'h200 + 32'(j), 0); tick();
        end
        idle(); repeat (4) tick();

        // Back-to-back push/pop across pointer wrap.
        for (int i = 0; i < 7; i++) begin
            drive(1, 5'(16 + i), 32'hA000 + 32'(i), 0, 0, 0, 0); tick();
        end
        idle(); repeat (2) tick();

        // r0 pops silently; response with nothing waiting sets sticky error.
        drive(1, 5'd0, 32'hFFFF, 0, 0, 0, 0); tick(); idle(); #1;
        chk("r0_we", we, 0);
        tick();
        chk("r0_drained_ready", in_ready, 1);
        drive(0, 0, 0, 0, 1, 32'hBAD, 0); tick(); idle(); #1;
        chk("err_set", rsp_err, 1);
        repeat (3) tick();
        chk("err_sticky", rsp_err, 1);

        // Flush with a simultaneous push: everything dropped.
        drive(1, 5'd10, 32'h1, 1, 0, 0, 0); tick();
        drive(1, 5'd11, 32'hB, 0, 0, 0, 0); tick();
        drive(1, 5'd12, 32'hC, 0, 0, 0, 0); tick();
        drive(1, 5'd13, 32'hD, 0, 0, 0, 1); #1;
        chk("flush_pre_ready", in_ready, 1);
        tick(); idle(); #1;
        chk("flush_ready", in_ready, 1);
        chk("flush_we", we, 0);
        repeat (3) tick();

        // Reset mid-operation; a late load return then reports an error.
        drive(1, 5'd14, 32'h0, 1, 0, 0, 0); tick();
        drive(1, 5'd15, 32'hF, 0, 0, 0, 0); tick();
        idle(); #2;
        resetn = 1'b0;
        mq.delete();
        m_err = 1'b0;
        #1;
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_err", rsp_err, 0);
        chk("rst_mid_we", we, 0);
        tick(); tick();
        resetn = 1'b1;
        drive(0, 0, 0, 0, 1, 32'hBEEF, 0); tick(); idle(); #1;
        chk("late_rvalid_err", rsp_err, 1);
        chk("late_rvalid_we", we, 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-order writeback entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  producer presents a writeback request.
REQ-005 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL have port in_waddr  input  5  destination register.
REQ-007 SHALL have port in_wdata  input  32  result data; ignored when in_wait=1.
REQ-008 SHALL have port in_wait  input  1  data arrives later on mem_rvalid (load).
REQ-009 SHALL have port mem_rvalid  input  1  load data return, in request order.
REQ-010 SHALL have port mem_rdata  input  32  load return data.
REQ-011 SHALL have port flush  input  1  discard all queued entries.
REQ-012 SHALL have ports we  output  1, waddr  output  5, wdata  output  32: register file write port, sampled by the register file on the negedge of the same cycle.
REQ-013 SHALL have ports fwd_raddr1, fwd_raddr2  input  5  forwarding lookup addresses.
REQ-014 SHALL have ports fwd_hit1/2  output  1, fwd_data1/2  output  32, fwd_stall1/2  output  1: lookup results.
REQ-015 SHALL have port rsp_err  output  1  sticky: mem_rvalid arrived with no waiting entry.

Function
REQ-016 SHALL store per entry: valid, addr, data, data_ok; entries leave strictly in arrival order.
REQ-017 SHALL drive in_ready = 1 exactly when occupancy < DEPTH (registered count; same-cycle pop does not raise it).
REQ-018 SHALL push on posedge when in_valid & in_ready & !flush; data_ok = !in_wait.
REQ-019 SHALL, on mem_rvalid, write mem_rdata into the oldest entry with data_ok=0 and set data_ok; if that entry is being pushed the same cycle, the push's own data is not targeted.
REQ-020 SHALL, on mem_rvalid with no entry waiting (including an in_wait push in the same cycle), set rsp_err and discard the data.
REQ-021 SHALL pop the head on posedge when head valid & data_ok; we/waddr/wdata are combinational from the head in that cycle.
REQ-022 SHALL drive we = head valid & data_ok & (addr != 0); an r0 head still pops with we=0.
REQ-023 SHALL allow push and pop in the same cycle with occupancy unchanged; pointers wrap modulo DEPTH.
REQ-024 SHALL forward: fwd_hitN=1 when any valid entry addr == fwd_raddrN != 0; the youngest match wins; fwd_dataN = its data; fwd_stallN = hit & !data_ok of that entry.
REQ-025 SHALL give forwarding lookups no visibility of same-cycle pushes or mem_rvalid data (registered state only).
REQ-026 SHALL, on flush, clear all entries at the next posedge, with priority over push and mem_rvalid; the head's combinational write in the flush cycle still occurs.

Reset
REQ-027 SHALL, with resetn low, immediately clear all entry valid bits, pointers, count and rsp_err; outputs become we=0, waddr=0, wdata=0, in_ready=1, fwd_hit*=0, fwd_stall*=0, fwd_data*=0.
REQ-028 SHALL discard in-flight loads on reset mid-operation; a late mem_rvalid after reset sets rsp_err.

Configuration
REQ-029 SHALL compile forwarding logic only when macro REG_WB_QUEUE_FWD_EN is defined; without it, fwd_hit*, fwd_stall* and fwd_data* are constant 0, the lookup inputs are unused, and REQ-001..028 are otherwise unchanged.

Verification
REQ-030 SHALL cover: push (r5, 0x1234, wait=0) into empty queue -> next cycle we=1, waddr=5, wdata=0x1234, then empty.
REQ-031 SHALL cover: push load r7 (wait=1), then push r8=0xAA -> no write until mem_rvalid with 0xDEAD; then r7=0xDEAD is written, then r8=0xAA, in order.
REQ-032 SHALL cover: 4 pushes with waits, no returns -> in_ready=0; a 5th in_valid is not accepted; one return -> pop, in_ready=1 the cycle after.
REQ-033 SHALL cover (FWD_EN): entries r3=0x11 then r3=0x22 queued -> fwd_raddr1=3 gives hit=1, data=0x22; fwd_raddr2=0 gives hit=0.
REQ-034 SHALL cover: push r0=0xFFFF -> pops with we=0; mem_rvalid on empty queue -> rsp_err=1 until resetn low.
REQ-035 SHALL cover: 3 queued entries plus flush asserted with in_valid -> queue empty, the push is dropped, in_ready=1.
